// File: rtl/fifo_ctrl.sv
// Pointer, occupancy and flag controller for a single-clock FIFO.
// Drives a dual-port RAM with a two-stage registered read path.
module fifo_ctrl #(
  parameter int DWIDTH       = 8,
  parameter int AWIDTH       = 4,
  parameter int ALMOST_FULL  = 12,
  parameter int ALMOST_EMPTY = 4
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              wrreq_i,
  input  logic              rdreq_i,
  output logic              wren_o,
  output logic [AWIDTH-1:0] wrpntr_o,
  output logic [AWIDTH-1:0] rdpntr_o,
  output logic              rdvalid_o,
  output logic              empty_o,
  output logic              full_o,
  output logic              almost_empty_o,
  output logic              almost_full_o,
  output logic [AWIDTH:0]   usedw_o,
  output logic              ovf_o,
  output logic              udf_o
);

  if (DWIDTH < 1) begin : g_bad_dwidth
    $error("fifo_ctrl: DWIDTH must be at least 1");
  end

  localparam logic [AWIDTH:0]   L_DEPTH = (AWIDTH+1)'(2**AWIDTH);
  localparam logic [AWIDTH:0]   L_AF    = (AWIDTH+1)'(ALMOST_FULL);
  localparam logic [AWIDTH:0]   L_AE    = (AWIDTH+1)'(ALMOST_EMPTY);
  localparam logic [AWIDTH:0]   L_U1    = (AWIDTH+1)'(1);
  localparam logic [AWIDTH-1:0] L_P1    = AWIDTH'(1);

  logic [AWIDTH-1:0] r_wrpntr;
  logic [AWIDTH-1:0] r_rdpntr;
  logic [AWIDTH:0]   r_usedw;
  logic              r_empty;
  logic              r_full;
  logic              r_aempty;
  logic              r_afull;
  logic [1:0]        r_rdv;
  logic              r_ovf;
  logic              r_udf;

  logic              w_wr_acc;
  logic              w_rd_acc;
  logic [AWIDTH:0]   w_usedw_nxt;

  assign w_wr_acc = wrreq_i & ~r_full;
  assign w_rd_acc = rdreq_i & ~r_empty;

  always_comb begin
    w_usedw_nxt = r_usedw;
    unique case ({w_wr_acc, w_rd_acc})
      2'b10:   w_usedw_nxt = r_usedw + L_U1;
      2'b01:   w_usedw_nxt = r_usedw - L_U1;
      default: w_usedw_nxt = r_usedw;
    endcase
  end

  // Flags come from the next count so they land on the same edge as usedw.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_wrpntr <= '0;
      r_rdpntr <= '0;
      r_usedw  <= '0;
      r_empty  <= 1'b1;
      r_full   <= 1'b0;
      r_aempty <= 1'b1;
      r_afull  <= 1'b0;
      r_rdv    <= '0;
      r_ovf    <= 1'b0;
      r_udf    <= 1'b0;
    end else begin
      if (w_wr_acc) r_wrpntr <= r_wrpntr + L_P1;
      if (w_rd_acc) r_rdpntr <= r_rdpntr + L_P1;
      r_usedw  <= w_usedw_nxt;
      r_empty  <= (w_usedw_nxt == '0);
      r_full   <= (w_usedw_nxt == L_DEPTH);
      r_aempty <= (w_usedw_nxt <= L_AE);
      r_afull  <= (w_usedw_nxt >= L_AF);
      r_rdv    <= {r_rdv[0], w_rd_acc};
      r_ovf    <= r_ovf | (wrreq_i & r_full);
      r_udf    <= r_udf | (rdreq_i & r_empty);
    end
  end

  assign wren_o         = w_wr_acc;
  assign wrpntr_o       = r_wrpntr;
  assign rdpntr_o       = r_rdpntr;
  assign rdvalid_o      = r_rdv[1];
  assign empty_o        = r_empty;
  assign full_o         = r_full;
  assign almost_empty_o = r_aempty;
  assign almost_full_o  = r_afull;
  assign usedw_o        = r_usedw;
  assign ovf_o          = r_ovf;
  assign udf_o          = r_udf;

endmodule

// File: tb/tb_fifo_ctrl.sv
// Bench for fifo_ctrl with a behavioural two-stage RAM and a
// data scoreboard popped on every rdvalid_o.
module tb_fifo_ctrl;

  logic       clk;
  logic       rst_n;
  logic       wrreq;
  logic       rdreq;
  logic [7:0] din;
  logic       wren;
  logic [3:0] wrpntr;
  logic [3:0] rdpntr;
  logic       rdvalid;
  logic       empty;
  logic       full;
  logic       aempty;
  logic       afull;
  logic [4:0] usedw;
  logic       ovf;
  logic       udf;

  fifo_ctrl #(
    .DWIDTH(8), .AWIDTH(4), .ALMOST_FULL(12), .ALMOST_EMPTY(4)
  ) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .wrreq_i(wrreq), .rdreq_i(rdreq),
    .wren_o(wren), .wrpntr_o(wrpntr), .rdpntr_o(rdpntr),
    .rdvalid_o(rdvalid), .empty_o(empty), .full_o(full),
    .almost_empty_o(aempty), .almost_full_o(afull),
    .usedw_o(usedw), .ovf_o(ovf), .udf_o(udf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] mem [16];
  logic [3:0] ram_addr;
  logic [7:0] q;

  always @(posedge clk) begin
    if (wren) mem[wrpntr] <= din;
    ram_addr <= rdpntr;
    q        <= mem[ram_addr];
  end

  int         n_vec = 0;
  int         n_err = 0;
  logic [7:0] sb [$];
  int         m_cnt;
  logic [3:0] m_wp;
  logic [3:0] m_rp;
  logic       m_ovf;
  logic       m_udf;

  always @(negedge clk) begin
    if (rdvalid) begin
      n_vec++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL rdata: rdvalid with empty scoreboard, q=%h", q);
      end else begin
        logic [7:0] e;
        e = sb.pop_front();
        if (q !== e) begin
          n_err++;
          $display("FAIL rdata: got %h expected %h", q, e);
        end
      end
    end
  end

  task automatic model_reset();
    m_cnt = 0;
    m_wp  = '0;
    m_rp  = '0;
    m_ovf = 1'b0;
    m_udf = 1'b0;
  endtask

  task automatic step(input logic wr, input logic rd, input logic [7:0] d);
    logic wacc;
    logic racc;
    wrreq = wr;
    rdreq = rd;
    din   = d;
    wacc  = wr && (m_cnt != 16);
    racc  = rd && (m_cnt != 0);
    if (wr && m_cnt == 16) m_ovf = 1'b1;
    if (rd && m_cnt == 0)  m_udf = 1'b1;
    if (wacc) begin
      sb.push_back(d);
      m_wp = m_wp + 4'd1;
    end
    if (racc) m_rp = m_rp + 4'd1;
    m_cnt = m_cnt + int'(wacc) - int'(racc);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [11:0] got;
    logic [11:0] exp;
    rst_n = 1'b0;
    wrreq = 1'b0;
    rdreq = 1'b0;
    din   = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    got = {wren, rdvalid, empty, full, aempty, afull, usedw, ovf};
    exp = {1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0};
    n_vec++;
    if (got !== exp || wrpntr !== 4'd0 || rdpntr !== 4'd0 || udf !== 1'b0) begin
      n_err++;
      $display("FAIL reset: got %h ptrs %h/%h udf %b expected %h", got, wrpntr, rdpntr, udf, exp);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_fill();
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 1'b0, 8'(i));
      n_vec++;
      if ({usedw, full, afull, empty, aempty} !==
          {5'(m_cnt), m_cnt == 16, m_cnt >= 12, m_cnt == 0, m_cnt <= 4}) begin
        n_err++;
        $display("FAIL fill[%0d]: usedw=%0d f=%b af=%b e=%b ae=%b expected usedw=%0d",
                 i, usedw, full, afull, empty, aempty, m_cnt);
      end
    end
  endtask

  task automatic test_overflow();
    wrreq = 1'b1;
    rdreq = 1'b0;
    din   = 8'hEE;
    #1;
    n_vec++;
    if (wren !== 1'b0) begin
      n_err++;
      $display("FAIL ovf_wren: got %b expected 0", wren);
    end
    step(1'b1, 1'b0, 8'hEE);
    n_vec++;
    if ({wrpntr, rdpntr, usedw, ovf} !== {m_wp, m_rp, 5'(m_cnt), m_ovf} || !m_ovf) begin
      n_err++;
      $display("FAIL ovf: wp=%0d rp=%0d usedw=%0d ovf=%b expected %0d %0d %0d 1",
               wrpntr, rdpntr, usedw, ovf, m_wp, m_rp, m_cnt);
    end
    step(1'b0, 1'b0, 8'h00);
    n_vec++;
    if (ovf !== 1'b1) begin
      n_err++;
      $display("FAIL ovf_sticky: got %b expected 1", ovf);
    end
  endtask

  task automatic test_drain();
    for (int k = 0; k < 18; k++) begin
      step(1'b0, k < 16, 8'h00);
      n_vec++;
      if (rdvalid !== (k >= 1 && k <= 16)) begin
        n_err++;
        $display("FAIL drain_rdvalid[%0d]: got %b expected %b", k, rdvalid, (k >= 1 && k <= 16));
      end
    end
    n_vec++;
    if ({empty, usedw} !== {1'b1, 5'd0} || sb.size() != 0) begin
      n_err++;
      $display("FAIL drain_end: empty=%b usedw=%0d left=%0d expected 1 0 0", empty, usedw, sb.size());
    end
  endtask

  task automatic test_underflow();
    step(1'b0, 1'b1, 8'h00);
    n_vec++;
    if ({rdpntr, usedw, udf} !== {m_rp, 5'(m_cnt), m_udf} || !m_udf) begin
      n_err++;
      $display("FAIL udf: rp=%0d usedw=%0d udf=%b expected %0d %0d 1", rdpntr, usedw, udf, m_rp, m_cnt);
    end
    for (int k = 0; k < 2; k++) begin
      step(1'b0, 1'b0, 8'h00);
      n_vec++;
      if (rdvalid !== 1'b0) begin
        n_err++;
        $display("FAIL udf_rdvalid[%0d]: got %b expected 0", k, rdvalid);
      end
    end
    step(1'b1, 1'b1, 8'hA5);
    n_vec++;
    if ({usedw, empty, udf} !== {5'd1, 1'b0, 1'b1}) begin
      n_err++;
      $display("FAIL rw_empty: usedw=%0d empty=%b udf=%b expected 1 0 1", usedw, empty, udf);
    end
  endtask

  task automatic test_stream();
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 8'(8'h50 + i));
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 1'b1, 8'(8'h80 + i));
      n_vec++;
      if ({usedw, wrpntr, rdpntr} !== {5'd5, m_wp, m_rp} || m_cnt != 5) begin
        n_err++;
        $display("FAIL stream[%0d]: usedw=%0d wp=%0d rp=%0d expected 5 %0d %0d",
                 i, usedw, wrpntr, rdpntr, m_wp, m_rp);
      end
    end
  endtask

  task automatic test_rw_full();
    for (int i = 0; i < 11; i++) step(1'b1, 1'b0, 8'(8'hC0 + i));
    n_vec++;
    if ({full, usedw} !== {1'b1, 5'd16}) begin
      n_err++;
      $display("FAIL refill: full=%b usedw=%0d expected 1 16", full, usedw);
    end
    step(1'b1, 1'b1, 8'hFF);
    n_vec++;
    if ({usedw, full, ovf, wrpntr, rdpntr} !== {5'd15, 1'b0, 1'b1, m_wp, m_rp}) begin
      n_err++;
      $display("FAIL rw_full: usedw=%0d full=%b ovf=%b wp=%0d rp=%0d expected 15 0 1 %0d %0d",
               usedw, full, ovf, wrpntr, rdpntr, m_wp, m_rp);
    end
  endtask

  task automatic test_mid_reset();
    logic [11:0] got;
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 8'h00);
    n_vec++;
    if (usedw !== 5'd9) begin
      n_err++;
      $display("FAIL pre_reset: usedw=%0d expected 9", usedw);
    end
    #2;
    rst_n = 1'b0;
    rdreq = 1'b0;
    #1;
    got = {wren, rdvalid, empty, full, aempty, afull, usedw, ovf};
    n_vec++;
    if (got !== {1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0} ||
        wrpntr !== 4'd0 || rdpntr !== 4'd0 || udf !== 1'b0) begin
      n_err++;
      $display("FAIL mid_reset: got %h ptrs %h/%h udf %b", got, wrpntr, rdpntr, udf);
    end
    sb.delete();
    model_reset();
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      step(1'b0, k == 0, 8'h00);
      n_vec++;
      if ({rdvalid, rdpntr, usedw} !== {1'b0, 4'd0, 5'd0}) begin
        n_err++;
        $display("FAIL post_reset[%0d]: rdvalid=%b rp=%0d usedw=%0d expected 0 0 0",
                 k, rdvalid, rdpntr, usedw);
      end
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_overflow();
    test_drain();
    test_underflow();
    test_stream();
    test_rw_full();
    test_mid_reset();
    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
